// File: rtl/vid_pixel_fifo_pkg.sv
// Shared video constants for the pixel FIFO and the memory requester.
// Holds the buffer geometry, the RGB565 pixel type and the black pixel constant.
package vid_pixel_fifo_pkg;

    localparam int DEPTH_DEFAULT = 256;
    localparam int AW_DEFAULT    = 8;

    typedef logic [15:0] rgb565_t;
    typedef logic [31:0] pix_pair_t;

    localparam rgb565_t RGB565_BLACK = 16'h0000;

    // Which half of the head dword the next pixel request consumes.
    typedef enum logic {
        HALF_LO = 1'b0,
        HALF_HI = 1'b1
    } half_e;

endpackage

// File: rtl/vid_pixel_fifo_if.sv
// Memory-read and pixel-request signals of the video pixel FIFO.
// The slave modport is the FIFO itself; master is its environment.
interface vid_pixel_fifo_if;
    import vid_pixel_fifo_pkg::*;

    pix_pair_t  mem_rd_data;
    logic       mem_rd_data_valid;
    logic [1:0] fifo_level;
    logic       pix_req;
    rgb565_t    pix_out;
    logic       pix_valid;
    logic       underflow;
    logic       overflow;

    modport master (
        output mem_rd_data, mem_rd_data_valid, pix_req,
        input  fifo_level, pix_out, pix_valid, underflow, overflow
    );

    modport slave (
        input  mem_rd_data, mem_rd_data_valid, pix_req,
        output fifo_level, pix_out, pix_valid, underflow, overflow
    );

endinterface

// File: rtl/sync_fifo_32.sv
// Dword storage for the pixel FIFO: simple dual-port RAM with registered read.
// A same-cycle write to the address being read is passed through to the output.
module sync_fifo_32 #(
    parameter int AW = 8
) (
    input  logic          mem_clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [1 << AW];

    // NOTE: RAM arrays carry no reset; clearing them would prevent block-RAM inference.
    always_ff @(posedge mem_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge mem_clk) begin
        rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/vid_pixel_fifo.sv
// Pixel FIFO between SDRAM read bursts (two RGB565 pixels per dword) and the
// video timing: one registered pixel per request, sticky under/overflow flags.
module vid_pixel_fifo
    import vid_pixel_fifo_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = AW_DEFAULT
) (
    input  logic             mem_clk,
    input  logic             reset,
    vid_pixel_fifo_if.slave  bus
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    half_e         hsel;
    pix_pair_t     head;
    logic          avail;
    logic          pix_take;
    logic          pop;
    logic          wr_accept;
    logic [1:0]    level_next;

    logic [1:0]    fifo_level_q;
    rgb565_t       pix_out_q;
    logic          pix_valid_q;
    logic          underflow_q;
    logic          overflow_q;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        avail      = (count != '0);
        pix_take   = bus.pix_req && avail;
        pop        = pix_take && (hsel == HALF_HI);
        wr_accept  = bus.mem_rd_data_valid && ((count != FULL) || pop);
        count_next = count;
        case ({wr_accept, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
        // Read one ahead so the RAM output always holds the head dword.
        rd_addr    = pop ? rd_ptr + 1'b1 : rd_ptr;
        level_next = (count_next == FULL) ? 2'b11 : count_next[AW-1:AW-2];
    end

    sync_fifo_32 #(.AW(AW)) u_ram (
        .mem_clk (mem_clk),
        .we      (wr_accept && !reset),
        .waddr   (wr_ptr),
        .wdata   (bus.mem_rd_data),
        .raddr   (rd_addr),
        .rdata   (head)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge mem_clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            hsel         <= HALF_LO;
            fifo_level_q <= 2'b00;
            pix_out_q    <= RGB565_BLACK;
            pix_valid_q  <= 1'b0;
            underflow_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr       <= rd_addr;
            count        <= count_next;
            fifo_level_q <= level_next;
            pix_valid_q  <= pix_take;
            if (pix_take) begin
                pix_out_q <= (hsel == HALF_HI) ? head[31:16] : head[15:0];
                hsel      <= (hsel == HALF_HI) ? HALF_LO : HALF_HI;
            end else begin
                pix_out_q <= RGB565_BLACK;
            end
            if (bus.pix_req && !avail) begin
                underflow_q <= 1'b1;
            end
            if (bus.mem_rd_data_valid && !wr_accept) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.fifo_level = fifo_level_q;
    assign bus.pix_out    = pix_out_q;
    assign bus.pix_valid  = pix_valid_q;
    assign bus.underflow  = underflow_q;
    assign bus.overflow   = overflow_q;

endmodule
